// File: rtl/aes_block_buffer.sv
// AES block buffer: packs 32-bit AHB read words into 128-bit blocks for
// the AES core and splits 128-bit result blocks back into 32-bit words.
//
// Ports
//   hclk, hrst           clock and async active-low reset
//   soft_clr             synchronous abort of both halves
//   shift_en, shiftout   read word strobe and data (first word = 127:96)
//   in_full              block held, master must stall reads
//   blk_out, blk_valid,  assembled block to AES core (valid/ready)
//   blk_ready
//   res_in, res_valid,   result block from AES core (valid/ready)
//   res_ready
//   shiftin, word_avail, write word to master, consumed on word_req
//   word_req
//   end_block            one-cycle pulse after last result word taken
module aes_block_buffer (
  input  logic         hclk,
  input  logic         hrst,
  input  logic         soft_clr,
  input  logic         shift_en,
  input  logic [31:0]  shiftout,
  output logic         in_full,
  output logic [127:0] blk_out,
  output logic         blk_valid,
  input  logic         blk_ready,
  input  logic [127:0] res_in,
  input  logic         res_valid,
  output logic         res_ready,
  output logic [31:0]  shiftin,
  output logic         word_avail,
  input  logic         word_req,
  output logic         end_block
);

  typedef enum logic [0:0] {
    OIDLE = 1'b0,
    OSEND = 1'b1
  } ostate_t;

  // ---------------- input side ----------------
  logic [127:0] ibuf;
  logic [1:0]   icnt;
  logic         ivld;
  logic         iacc;
  logic         ihs;

  // Words are accepted only while no block is held; a handshake
  // cycle still has ivld=1 so a coincident strobe is dropped.
  assign iacc = shift_en & ~ivld;
  assign ihs  = ivld & blk_ready;

  always_ff @(posedge hclk or negedge hrst) begin
    if (!hrst) begin
      ibuf <= '0;
      icnt <= '0;
      ivld <= 1'b0;
    end else if (soft_clr) begin
      ibuf <= '0;
      icnt <= '0;
      ivld <= 1'b0;
    end else begin
      if (iacc) begin
        ibuf <= {ibuf[95:0], shiftout};
        icnt <= icnt + 2'd1;
        if (icnt == 2'd3)
          ivld <= 1'b1;
      end
      if (ihs)
        ivld <= 1'b0;
    end
  end

  assign blk_valid = ivld;
  assign in_full   = ivld;
  assign blk_out   = ibuf;

  // ---------------- output side ----------------
  ostate_t      state;
  ostate_t      state_nxt;
  logic [127:0] obuf;
  logic [127:0] obuf_nxt;
  logic [1:0]   ocnt;
  logic [1:0]   ocnt_nxt;
  logic         eb;
  logic         eb_nxt;

  always_ff @(posedge hclk or negedge hrst) begin
    if (!hrst) begin
      state <= OIDLE;
      obuf  <= '0;
      ocnt  <= '0;
      eb    <= 1'b0;
    end else begin
      state <= state_nxt;
      obuf  <= obuf_nxt;
      ocnt  <= ocnt_nxt;
      eb    <= eb_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    obuf_nxt  = obuf;
    ocnt_nxt  = ocnt;
    eb_nxt    = 1'b0;
    if (soft_clr) begin
      state_nxt = OIDLE;
      obuf_nxt  = '0;
      ocnt_nxt  = '0;
    end else begin
      unique case (state)
        OIDLE: begin
          if (res_valid) begin
            obuf_nxt  = res_in;
            ocnt_nxt  = '0;
            state_nxt = OSEND;
          end
        end
        OSEND: begin
          if (word_req) begin
            ocnt_nxt = ocnt + 2'd1;
            if (ocnt == 2'd3) begin
              state_nxt = OIDLE;
              eb_nxt    = 1'b1;
            end
          end
        end
        default: state_nxt = OIDLE;
      endcase
    end
  end

  always_comb begin
    shiftin = '0;
    if (state == OSEND) begin
      unique case (ocnt)
        2'd0:    shiftin = obuf[127:96];
        2'd1:    shiftin = obuf[95:64];
        2'd2:    shiftin = obuf[63:32];
        default: shiftin = obuf[31:0];
      endcase
    end
  end

  assign res_ready  = (state == OIDLE);
  assign word_avail = (state == OSEND);
  assign end_block  = eb;

endmodule

// File: tb/tb_aes_block_buffer.sv
// Directed testbench for aes_block_buffer.
// Inputs change 1 time unit after a rising edge; outputs sampled there too.
module tb_aes_block_buffer;

  logic         tb_clk;
  logic         hrst;
  logic         soft_clr;
  logic         shift_en;
  logic [31:0]  shiftout;
  logic         in_full;
  logic [127:0] blk_out;
  logic         blk_valid;
  logic         blk_ready;
  logic [127:0] res_in;
  logic         res_valid;
  logic         res_ready;
  logic [31:0]  shiftin;
  logic         word_avail;
  logic         word_req;
  logic         end_block;

  int n_chk = 0;
  int n_err = 0;

  aes_block_buffer dut (
    .hclk       (tb_clk),
    .hrst       (hrst),
    .soft_clr   (soft_clr),
    .shift_en   (shift_en),
    .shiftout   (shiftout),
    .in_full    (in_full),
    .blk_out    (blk_out),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .res_in     (res_in),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .shiftin    (shiftin),
    .word_avail (word_avail),
    .word_req   (word_req),
    .end_block  (end_block)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".in_full"}, 128'(in_full), 128'd0);
    chk({tag, ".blk_valid"}, 128'(blk_valid), 128'd0);
    chk({tag, ".res_ready"}, 128'(res_ready), 128'd1);
    chk({tag, ".word_avail"}, 128'(word_avail), 128'd0);
    chk({tag, ".shiftin"}, 128'(shiftin), 128'd0);
    chk({tag, ".end_block"}, 128'(end_block), 128'd0);
  endtask

  function automatic logic [31:0] wsel(input logic [127:0] v,
                                       input int i);
    return v[127-32*i -: 32];
  endfunction

  // Push four words of blk, checking blk_valid only after the 4th.
  task automatic push_blk(input string tag, input logic [127:0] blk);
    for (int i = 0; i < 4; i++) begin
      shift_en = 1'b1;
      shiftout = wsel(blk, i);
      step();
      if (i == 2)
        chk({tag, ".early_valid"}, 128'(blk_valid), 128'd0);
    end
    shift_en = 1'b0;
    chk({tag, ".valid"}, 128'(blk_valid), 128'd1);
    chk({tag, ".blk_out"}, blk_out, blk);
  endtask

  task automatic take_blk();
    blk_ready = 1'b1;
    step();
    blk_ready = 1'b0;
  endtask

  logic [127:0] r1;
  logic [127:0] r2;
  logic [127:0] b3;
  logic [127:0] b4;
  logic [6:0]   pat;
  int           idx;
  int           eb_cnt;

  initial begin
    r1 = 128'h00112233445566778899aabbccddeeff;
    r2 = 128'ha0a1a2a3b0b1b2b3c0c1c2c3d0d1d2d3;
    b3 = 128'h0123456789abcdeffedcba9876543210;
    b4 = 128'h11111111222222223333333344444444;
    hrst = 1'b0; soft_clr = 1'b0; shift_en = 1'b0;
    shiftout = '0; blk_ready = 1'b0; res_in = '0;
    res_valid = 1'b0; word_req = 1'b0;
    step();
    chk_idle("reset");
    chk("reset.blk_out", blk_out, 128'd0);
    hrst = 1'b1;
    step();

    // block assembly
    push_blk("asm", 128'h3243f6a8885a308d313198a2e0370734);

    // strobe while full is dropped, also on the handshake cycle
    shift_en = 1'b1; shiftout = 32'hdeadbeef;
    step();
    chk("drop.in_full", 128'(in_full), 128'd1);
    chk("drop.blk_out", blk_out,
        128'h3243f6a8885a308d313198a2e0370734);
    blk_ready = 1'b1;
    step();
    blk_ready = 1'b0; shift_en = 1'b0;
    chk("hs.valid", 128'(blk_valid), 128'd0);
    push_blk("after_hs", b3);
    take_blk();

    // result serialisation, word_req held high
    res_in = r1; res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    chk("ser.res_ready", 128'(res_ready), 128'd0);
    chk("ser.avail", 128'(word_avail), 128'd1);
    chk("ser.w0", 128'(shiftin), 128'(32'h00112233));
    word_req = 1'b1;
    eb_cnt = 0;
    for (int i = 1; i < 4; i++) begin
      step();
      chk($sformatf("ser.w%0d", i), 128'(shiftin), 128'(wsel(r1, i)));
      if (end_block) eb_cnt++;
    end
    step();
    word_req = 1'b0;
    if (end_block) eb_cnt++;
    chk("ser.end_block", 128'(end_block), 128'd1);
    chk("ser.res_ready_back", 128'(res_ready), 128'd1);
    chk("ser.shiftin_idle", 128'(shiftin), 128'd0);
    step();
    if (end_block) eb_cnt++;
    chk("ser.eb_count", 128'(eb_cnt), 128'd1);

    // gapped word_req 1,0,0,1,1,0,1
    res_in = r2; res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    pat = 7'b1001101;
    idx = 0;
    for (int i = 0; i < 7; i++) begin
      word_req = pat[6-i];
      step();
      if (pat[6-i]) idx++;
      if (idx < 4)
        chk($sformatf("gap.c%0d.w", i), 128'(shiftin),
            128'(wsel(r2, idx)));
      chk($sformatf("gap.c%0d.eb", i), 128'(end_block),
          128'(idx == 4 && pat[6-i]));
    end
    word_req = 1'b0;
    chk("gap.idle", 128'(word_avail), 128'd0);
    step();

    // soft_clr mid-block and mid-OSEND
    shift_en = 1'b1; shiftout = 32'hcafef00d;
    step(); step();
    shift_en = 1'b0;
    res_in = r1; res_valid = 1'b1;
    step();
    res_valid = 1'b0; word_req = 1'b1;
    step();
    word_req = 1'b0; soft_clr = 1'b1;
    step();
    soft_clr = 1'b0;
    chk_idle("sclr");
    chk("sclr.blk_out", blk_out, 128'd0);
    push_blk("sclr.next", b4);
    take_blk();

    // async reset mid-OSEND with a partial block
    shift_en = 1'b1; shiftout = 32'hbadc0de5;
    res_in = r2; res_valid = 1'b1;
    step(); step();
    shift_en = 1'b0; res_valid = 1'b0; word_req = 1'b1;
    step();
    chk("hrst.pre_avail", 128'(word_avail), 128'd1);
    word_req = 1'b0;
    hrst = 1'b0;
    #1;
    chk_idle("hrst");
    step();
    hrst = 1'b1;
    step();
    push_blk("hrst.next", b3);
    take_blk();

    // concurrent assembly and serialisation
    res_in = r2; res_valid = 1'b1;
    shift_en = 1'b1; shiftout = wsel(b4, 0);
    step();
    res_valid = 1'b0;
    chk("conc.w0", 128'(shiftin), 128'(wsel(r2, 0)));
    word_req = 1'b1;
    for (int i = 1; i < 4; i++) begin
      shiftout = wsel(b4, i);
      step();
      chk($sformatf("conc.w%0d", i), 128'(shiftin),
          128'(wsel(r2, i)));
    end
    shift_en = 1'b0;
    chk("conc.blk_valid", 128'(blk_valid), 128'd1);
    chk("conc.blk_out", blk_out, b4);
    step();
    word_req = 1'b0;
    chk("conc.end_block", 128'(end_block), 128'd1);
    chk("conc.blk_hold", blk_out, b4);
    take_blk();
    chk("conc.drained", 128'(blk_valid), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
